// File: rtl/lib_mem.sv
// Shared types and helpers for the data-memory bus: FSM state encoding,
// word geometry and request address validation.
package lib_mem;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} MEM_STATE;

  localparam int WORD_BITS  = 32;
  localparam int BYTE_BITS  = 8;
  localparam int WORD_BYTES = WORD_BITS / BYTE_BITS;

  // True when the byte address is not word aligned or falls past the last word.
  function automatic logic addr_err(input logic [WORD_BITS-1:0] addr,
                                    input int unsigned          depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_BITS-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port word RAM with synchronous write and registered read port.
// The read register holds its value until the next read.
module sp_ram
  import lib_mem::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)          rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Target end of the CPU data-memory port: accepts one word request at a time,
// waits WAIT cycles, then commits it and pulses ready with data or err.
module dmem_responder
  import lib_mem::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 write_enab,
  input  logic [WORD_BITS-1:0] addr,
  input  logic [WORD_BITS-1:0] write_data,
  output logic                 ready,
  output logic [WORD_BITS-1:0] read_data,
  output logic                 err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  MEM_STATE             state;
  logic [3:0]           cnt;
  logic [WORD_BITS-1:0] lat_addr;
  logic [WORD_BITS-1:0] lat_wdata;
  logic                 lat_we;

  logic                 accept;
  logic                 commit;
  logic [WORD_BITS-1:0] c_addr;
  logic [WORD_BITS-1:0] c_wdata;
  logic                 c_we;
  logic                 c_err;
  logic                 ram_en;

  // With no wait states the commit edge is the accept edge, so the access
  // must come straight from the bus rather than from the request latch.
  always_comb begin
    accept  = req && (state == MEM_IDLE || state == MEM_RESP);
    c_addr  = (WAIT == 0) ? addr       : lat_addr;
    c_wdata = (WAIT == 0) ? write_data : lat_wdata;
    c_we    = (WAIT == 0) ? write_enab : lat_we;
    commit  = (WAIT == 0) ? accept : (state == MEM_WAIT && cnt == 4'd1);
    c_err   = addr_err(c_addr, DEPTH);
    ram_en  = commit && !c_err && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MEM_IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
    end else begin
      ready <= commit;
      err   <= commit && c_err;
      case (state)
        MEM_IDLE, MEM_RESP: begin
          if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= write_data;
            lat_we    <= write_enab;
            cnt       <= WAIT_CNT;
            state     <= (WAIT == 0) ? MEM_RESP : MEM_WAIT;
          end else begin
            state <= MEM_IDLE;
          end
        end
        MEM_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= MEM_RESP;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

  sp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (c_we),
    .addr  (c_addr[AW+1:2]),
    .wdata (c_wdata),
    .rdata (read_data)
  );

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the data memory bus: the target end of the CPU's data-memory port. Accepts word read/write requests from the CPU, performs them against an internal word-addressed RAM after a configurable number of wait states, and returns a one-cycle `ready` pulse with read data or an error flag. It lets the core run against memory with realistic latency instead of an ideal combinational array, and it serves as the reusable target model for the multi-cycle core.

## Interface
- `DEPTH`, 64: RAM size in 32-bit words; must be a power of two, 2..4096.
- `WAIT`, 2: wait states inserted before `ready`; legal range 0..15.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request strobe; sampled only while the block can accept.
- `write_enab` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr` in 32: byte address; sampled with `req`.
- `write_data` in 32: write word; sampled with `req`.
- `ready` out 1: one-cycle completion pulse.
- `read_data` out 32: read result; valid when `ready`=1, held until the next read completes.
- `err` out 1: qualifies `ready`; 1 = request rejected.

## Operation
- States: IDLE, WAIT, RESP.
- Accept condition: state is IDLE, or state is RESP (back-to-back). When `req`=1 under the accept condition, latch `addr`, `write_enab`, and `write_data`, and set the internal counter to `WAIT`.
- Decode of latched request:
  - Misaligned (`addr[1:0]`≠0) or out of range (`addr[31:2]` ≥ `DEPTH`) is an error. The access is not performed, and RESP is entered with `err`=1.
  - Otherwise the word index is `addr[log2(DEPTH)+1:2]`.
- Transitions:
  - IDLE, or RESP with `req`=1: go to WAIT if `WAIT`>0, else go to RESP.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, the next state is RESP.
  - RESP: go to WAIT or RESP if `req`=1 (new request accepted), else go to IDLE.
- Access commit happens on the clock edge that enters RESP.
  - A write updates RAM at that edge.
  - A read registers the RAM word into `read_data` at that edge.
  - Write and error responses leave `read_data` unchanged.
- `ready`=1 exactly in RESP. `err` is meaningful only when `ready`=1 and is 0 otherwise.
- `req` outside the accept condition is ignored. It is neither queued nor able to alter latched fields.
- Write-then-read to the same word returns the new value, because the write has committed before the read is accepted.

## Timing
- Latency: a request sampled at edge N produces `ready`=1 during cycle N+`WAIT`+1.
- Throughput with continuous `req`: one response per `WAIT`+1 cycles. With `WAIT`=0, `ready` is high every cycle.
- Reset (synchronous):
  - state=IDLE, counter=0, `ready`=0, `err`=0, `read_data`=0.
  - RAM contents are not cleared.
- Reset mid-transaction (in WAIT): the request is aborted, a pending write is never committed, and no `ready` is produced.
- Reset asserted in the same cycle as `req`: reset wins and the request is dropped.
- The requester may deassert `req` immediately after it is sampled. Holding `req` high through RESP issues a new request.

## Structure
- Package `lib_mem` holds:
  - `typedef enum logic[1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} MEM_STATE;`
  - Word/byte width constants.
  - An error-check function taking (addr, depth) and returning the misaligned-or-out-of-range result.
- Sub-module `sp_ram`: single-port RAM with a synchronous write/read and a `DEPTH` parameter. `dmem_responder` owns the FSM, counter, request latch, and output registers, and drives `sp_ram` enables only on the commit cycle.

## Test plan
- Reset, then `WAIT`=2: write 0xDEADBEEF to addr 0x10 at edge 0 gives `ready`=1, `err`=0 in cycle 3. A read of 0x10 sampled at edge 4 gives `ready` in cycle 7 with `read_data`=0xDEADBEEF.
- `WAIT`=0 with `req` held high, reading addresses 0x0, 0x4, 0x8 (preloaded 1, 2, 3): `ready` is high on 3 consecutive cycles with `read_data` 1, 2, 3.
- Error checks:
  - Read of addr 0x13 (misaligned) gives `ready`=1, `err`=1, and `read_data` keeps its previous value.
  - Write to addr 4·`DEPTH` gives `err`=1, and a follow-up read of word 0 shows it was not overwritten.
- `WAIT`=3: `req` pulses in WAIT cycles are ignored, and only one `ready` follows each accepted request.
- `WAIT`=4: assert `reset` 2 cycles after a write of 0x12345678 to 0x20. Expected:
  - No `ready`; all outputs read 0 the cycle after reset.
  - A later read of 0x20 returns the old contents.
